// File: rtl/dds_sample_top.sv
// dds_sample_top: UART-controlled two-channel pattern PWM plus an 8-bit DDS sine source.
// Ports:
//   sys_clk, sys_rst_n               clock and asynchronous active-low reset
//   uart_rxd / uart_txd              8N1 command input / acknowledge output
//   led                              toggles on every accepted packet
//   pwm_port, pwm_slow_port          PWM channels 1 and 2
//   pwm_diff_port_p/_n               channel 1 as a differential pair
//   dac_data, ad9748_sleep           DDS sample (offset binary) and DAC sleep control
//   adc_clk_p/_n, dds_clk0_p/_n      sys_clk/2 clock pairs
//   debug_uart_tx / debug_uart_rx    combinational copies of uart_rxd / uart_txd

// One PWM channel: holds its own config and walks the pulse pattern one bit per PWM cycle.
module dds_pwm_chan (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        cfg_en,
  input  logic [7:0]  cfg_duty,
  input  logic [15:0] cfg_period,
  input  logic [7:0]  cfg_pnum,
  input  logic [31:0] cfg_pat,
  output logic        pwm
);
  logic        en, done;
  logic [7:0]  duty, pnum, pcount;
  logic [15:0] period, cnt;
  logic [31:0] pat;
  logic [4:0]  pidx;

  // Config capture, cycle counter, pattern index, pulse counter and registered output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en <= 1'b0; done <= 1'b0; duty <= 8'd0; pnum <= 8'd0; pcount <= 8'd0;
      period <= 16'd0; cnt <= 16'd0; pat <= 32'd0; pidx <= 5'd0; pwm <= 1'b0;
    end else if (load) begin
      en <= cfg_en; duty <= cfg_duty; period <= cfg_period; pnum <= cfg_pnum; pat <= cfg_pat;
      cnt <= 16'd0; pidx <= 5'd0; pcount <= 8'd0; done <= 1'b0; pwm <= 1'b0;
    end else if (en && !done) begin
      // duty > period keeps the compare true for the whole cycle
      pwm <= (cnt < {8'd0, duty}) && pat[pidx];
      if (cnt == period) begin
        cnt    <= 16'd0;
        pidx   <= pidx + 5'd1;
        pcount <= pcount + 8'd1;
        if (pnum != 8'd0 && (pcount + 8'd1) == pnum) done <= 1'b1;
      end else begin
        cnt <= cnt + 16'd1;
      end
    end else begin
      pwm <= 1'b0;
    end
  end
endmodule

module dds_sample_top #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115200
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       uart_rxd,
  output logic       uart_txd,
  output logic       led,
  output logic       pwm_port,
  output logic       pwm_slow_port,
  output logic       pwm_diff_port_p,
  output logic       pwm_diff_port_n,
  output logic [7:0] dac_data,
  output logic       ad9748_sleep,
  output logic       adc_clk_p,
  output logic       adc_clk_n,
  output logic       dds_clk0_p,
  output logic       dds_clk0_n,
  output logic       debug_uart_tx,
  output logic       debug_uart_rx
);
  localparam int BIT_CYC = CLK_FREQ / BAUD_RATE;
  localparam logic [15:0] BIT_LAST  = 16'(BIT_CYC - 1);
  localparam logic [15:0] HALF_LAST = 16'(BIT_CYC / 2 - 1);

  typedef enum logic [1:0] {P_IDLE, P_PAYLOAD, P_TAIL} pstate_t;

  // Quarter-wave table: round(127*sin(i*pi/126)), so entry 63 is the full-scale peak
  function automatic logic [6:0] qtab(input logic [5:0] i);
    logic [6:0] q;
    case (i)
      6'd0: q=7'd0;    6'd1: q=7'd3;    6'd2: q=7'd6;    6'd3: q=7'd9;    6'd4: q=7'd13;   6'd5: q=7'd16;   6'd6: q=7'd19;   6'd7: q=7'd22;
      6'd8: q=7'd25;   6'd9: q=7'd28;   6'd10: q=7'd31;  6'd11: q=7'd34;  6'd12: q=7'd37;  6'd13: q=7'd40;  6'd14: q=7'd43;  6'd15: q=7'd46;
      6'd16: q=7'd49;  6'd17: q=7'd52;  6'd18: q=7'd55;  6'd19: q=7'd58;  6'd20: q=7'd61;  6'd21: q=7'd64;  6'd22: q=7'd66;  6'd23: q=7'd69;
      6'd24: q=7'd72;  6'd25: q=7'd74;  6'd26: q=7'd77;  6'd27: q=7'd79;  6'd28: q=7'd82;  6'd29: q=7'd84;  6'd30: q=7'd86;  6'd31: q=7'd89;
      6'd32: q=7'd91;  6'd33: q=7'd93;  6'd34: q=7'd95;  6'd35: q=7'd97;  6'd36: q=7'd99;  6'd37: q=7'd101; 6'd38: q=7'd103; 6'd39: q=7'd105;
      6'd40: q=7'd107; 6'd41: q=7'd108; 6'd42: q=7'd110; 6'd43: q=7'd112; 6'd44: q=7'd113; 6'd45: q=7'd114; 6'd46: q=7'd116; 6'd47: q=7'd117;
      6'd48: q=7'd118; 6'd49: q=7'd119; 6'd50: q=7'd120; 6'd51: q=7'd121; 6'd52: q=7'd122; 6'd53: q=7'd123; 6'd54: q=7'd124; 6'd55: q=7'd124;
      6'd56: q=7'd125; 6'd57: q=7'd126; 6'd58: q=7'd126; 6'd59: q=7'd126; 6'd60: q=7'd127; 6'd61: q=7'd127; 6'd62: q=7'd127;
      default: q=7'd127;
    endcase
    return q;
  endfunction

  // Full-wave sine: phase bit 6 mirrors the table index, bit 7 flips the sign around 0x80
  function automatic logic [7:0] sine(input logic [7:0] ph);
    logic [6:0] a;
    a = qtab(ph[6] ? ~ph[5:0] : ph[5:0]);
    return ph[7] ? (8'h80 - {1'b0, a}) : (8'h80 + {1'b0, a});
  endfunction

  logic [2:0]  rx_sync;
  logic        rx_busy, rx_valid;
  logic [15:0] rx_cnt, tx_cnt;
  logic [3:0]  rx_bit, tx_bit, idx, next_idx;
  logic [7:0]  rx_shift, ack_byte;
  pstate_t     state, next_state;
  logic        ack_go, accept, apply;
  logic [95:0] pay;
  logic        tx_busy;
  logic [9:0]  tx_shift;
  logic        dds_en, clk2;
  logic [31:0] ftw, phase;
  logic        ld1, ld2, ldd, unused_bits;

  // Payload fields, B1 at the top of the shift register
  wire [7:0]  f_func   = pay[95:88];
  wire [7:0]  f_ch     = pay[87:80];
  wire [7:0]  f_ctrl   = pay[79:72];
  wire [7:0]  f_duty   = pay[71:64];
  wire [15:0] f_period = pay[63:48];
  wire [7:0]  f_pnum   = pay[47:40];
  wire [31:0] f_pat    = pay[39:8];
  assign unused_bits = ^{pay[7:0], f_ctrl[7:1]};

  // rxd synchroniser; the third stage gives the previous value for edge detection
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) rx_sync <= 3'b111;
    else            rx_sync <= {rx_sync[1:0], uart_rxd};
  end

  // UART receiver: half a bit to the start mid-point, then a full bit per sample
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx_busy <= 1'b0; rx_valid <= 1'b0; rx_cnt <= 16'd0; rx_bit <= 4'd0; rx_shift <= 8'd0;
    end else begin
      rx_valid <= 1'b0;
      if (!rx_busy) begin
        if (rx_sync[2] && !rx_sync[1]) begin
          rx_busy <= 1'b1; rx_cnt <= 16'd0; rx_bit <= 4'd0;
        end
      end else if (rx_cnt == ((rx_bit == 4'd0) ? HALF_LAST : BIT_LAST)) begin
        rx_cnt <= 16'd0;
        if (rx_bit == 4'd9) begin
          rx_busy  <= 1'b0;
          rx_valid <= rx_sync[1];   // stop bit must be 1
        end else begin
          if (rx_bit != 4'd0) rx_shift <= {rx_sync[1], rx_shift[7:1]};
          rx_bit <= rx_bit + 4'd1;
        end
      end else begin
        rx_cnt <= rx_cnt + 16'd1;
      end
    end
  end

  // Parser state register, payload shift register and the delayed apply strobe
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= P_IDLE; idx <= 4'd0; pay <= 96'd0; apply <= 1'b0;
    end else begin
      state <= next_state;
      idx   <= next_idx;
      apply <= accept;
      if (state == P_PAYLOAD && rx_valid) pay <= {pay[87:0], rx_shift};
    end
  end

  // Parser next-state and acknowledge request
  always_comb begin
    next_state = state;
    next_idx   = idx;
    ack_go     = 1'b0;
    ack_byte   = 8'hEE;
    accept     = 1'b0;
    case (state)
      P_IDLE: begin
        if (rx_valid && rx_shift == 8'h55) begin
          next_state = P_PAYLOAD;
          next_idx   = 4'd0;
        end else begin
          next_state = P_IDLE;
        end
      end
      P_PAYLOAD: begin
        if (rx_valid) begin
          next_idx = idx + 4'd1;
          if (idx == 4'd11) next_state = P_TAIL;
          else              next_state = P_PAYLOAD;
        end else begin
          next_state = P_PAYLOAD;
        end
      end
      P_TAIL: begin
        if (rx_valid) begin
          ack_go     = 1'b1;
          next_state = P_IDLE;
          if (rx_shift == 8'hAA) begin
            accept   = 1'b1;
            ack_byte = 8'hA5;
          end else begin
            accept   = 1'b0;
          end
        end else begin
          next_state = P_TAIL;
        end
      end
      default: next_state = P_IDLE;
    endcase
  end

  assign ld1 = apply && f_func == 8'h01 && f_ch == 8'h01;
  assign ld2 = apply && f_func == 8'h01 && f_ch == 8'h02;
  assign ldd = apply && f_func == 8'h02;

  // UART transmitter; requests arriving while busy are dropped
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tx_busy <= 1'b0; tx_cnt <= 16'd0; tx_bit <= 4'd0; tx_shift <= 10'h3FF; uart_txd <= 1'b1;
    end else if (!tx_busy) begin
      uart_txd <= 1'b1;
      if (ack_go) begin
        tx_busy  <= 1'b1; tx_cnt <= 16'd0; tx_bit <= 4'd0;
        tx_shift <= {1'b1, ack_byte, 1'b0};
        uart_txd <= 1'b0;
      end
    end else if (tx_cnt == BIT_LAST) begin
      tx_cnt <= 16'd0;
      if (tx_bit == 4'd9) begin
        tx_busy  <= 1'b0;
        uart_txd <= 1'b1;
      end else begin
        uart_txd <= tx_shift[1];
        tx_shift <= {1'b1, tx_shift[9:1]};
        tx_bit   <= tx_bit + 4'd1;
      end
    end else begin
      tx_cnt <= tx_cnt + 16'd1;
    end
  end

  // Packet LED, DDS config, phase accumulator and registered sine output
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      led <= 1'b0; dds_en <= 1'b0; ftw <= 32'd0; phase <= 32'd0;
      dac_data <= 8'h80; ad9748_sleep <= 1'b1;
    end else begin
      if (apply) led <= ~led;
      if (ldd) begin
        dds_en <= f_ctrl[0];
        ftw    <= f_pat;
      end
      phase        <= dds_en ? (phase + ftw) : 32'd0;
      dac_data     <= dds_en ? sine(phase[31:24]) : 8'h80;
      ad9748_sleep <= ~dds_en;
    end
  end

  // Free-running sys_clk/2 toggle shared by both clock pairs
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) clk2 <= 1'b0;
    else            clk2 <= ~clk2;
  end

  dds_pwm_chan u_ch1 (
    .clk(sys_clk), .rst_n(sys_rst_n), .load(ld1), .cfg_en(f_ctrl[0]), .cfg_duty(f_duty),
    .cfg_period(f_period), .cfg_pnum(f_pnum), .cfg_pat(f_pat), .pwm(pwm_port)
  );
  dds_pwm_chan u_ch2 (
    .clk(sys_clk), .rst_n(sys_rst_n), .load(ld2), .cfg_en(f_ctrl[0]), .cfg_duty(f_duty),
    .cfg_period(f_period), .cfg_pnum(f_pnum), .cfg_pat(f_pat), .pwm(pwm_slow_port)
  );

  assign pwm_diff_port_p = pwm_port;
  assign pwm_diff_port_n = ~pwm_port;
  assign adc_clk_p       = clk2;
  assign adc_clk_n       = ~clk2;
  assign dds_clk0_p      = clk2;
  assign dds_clk0_n      = ~clk2;
  assign debug_uart_tx   = uart_rxd;
  assign debug_uart_rx   = uart_txd;
endmodule

// File: tb/tb_dds_sample_top.sv
// tb_dds_sample_top: directed packet bench for dds_sample_top at 10 clocks per UART bit.
module tb_dds_sample_top;
  localparam int BIT = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rxd = 1'b1;
  logic       txd, led, pwm_p, pwm_s, dp, dn, sleep, ac_p, ac_n, dc_p, dc_n, dbg_tx, dbg_rx;
  logic [7:0] dac;

  int n_total = 0;
  int n_bad   = 0;
  logic exp_led = 1'b0;

  int hi_p, hi_s, rise_p, min_gap, max_run, diff_err;
  logic [7:0] dmin, dmax;

  always #5 clk = ~clk;

  dds_sample_top #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000)) dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .uart_rxd(rxd), .uart_txd(txd), .led(led),
    .pwm_port(pwm_p), .pwm_slow_port(pwm_s), .pwm_diff_port_p(dp), .pwm_diff_port_n(dn),
    .dac_data(dac), .ad9748_sleep(sleep), .adc_clk_p(ac_p), .adc_clk_n(ac_n),
    .dds_clk0_p(dc_p), .dds_clk0_n(dc_n), .debug_uart_tx(dbg_tx), .debug_uart_rx(dbg_rx)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rxd = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (BIT) @(negedge clk);
    end
    rxd = 1'b1;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic send_pkt(input logic [111:0] pkt);
    for (int i = 0; i < 14; i++) send_byte(pkt[111-8*i -: 8]);
  endtask

  task automatic get_ack(output logic [7:0] v);
    int t;
    t = 0;
    v = 8'h00;
    while (txd !== 1'b0 && t < 16 * 10 * BIT) begin
      @(negedge clk);
      t++;
    end
    if (t < 16 * 10 * BIT) begin
      repeat (BIT / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (BIT) @(negedge clk);
        v[i] = txd;
      end
      repeat (BIT) @(negedge clk);
    end
  endtask

  task automatic xfer(input logic [111:0] pkt, input logic [7:0] exp_ack, input string tag);
    logic [7:0] a;
    fork
      get_ack(a);
      send_pkt(pkt);
    join
    check({tag, "_ack"}, {24'd0, a}, {24'd0, exp_ack});
    check({tag, "_led"}, {31'd0, led}, {31'd0, exp_led});
  endtask

  task automatic measure(input int len);
    logic prev, cur;
    int last_rise, run;
    hi_p = 0; hi_s = 0; rise_p = 0; min_gap = 1000000; max_run = 0; diff_err = 0;
    dmin = 8'hFF; dmax = 8'h00; last_rise = -1; run = 0;
    @(negedge clk);
    prev = pwm_p;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      cur = pwm_p;
      if (cur) hi_p++;
      if (pwm_s) hi_s++;
      if (cur && !prev) begin
        rise_p++;
        if (last_rise >= 0 && (i - last_rise) < min_gap) min_gap = i - last_rise;
        last_rise = i;
      end
      run = cur ? run + 1 : 0;
      if (run > max_run) max_run = run;
      if (dp !== cur || dn !== ~cur) diff_err++;
      if (dac < dmin) dmin = dac;
      if (dac > dmax) dmax = dac;
      prev = cur;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_txd"},   {31'd0, txd},   32'd1);
    check({tag, "_led"},   {31'd0, led},   32'd0);
    check({tag, "_pwm"},   {30'd0, pwm_p, pwm_s}, 32'd0);
    check({tag, "_diff"},  {30'd0, dp, dn}, 32'd1);
    check({tag, "_dac"},   {24'd0, dac},   32'h80);
    check({tag, "_sleep"}, {31'd0, sleep}, 32'd1);
    check({tag, "_clkp"},  {30'd0, ac_p, dc_p}, 32'd0);
  endtask

  localparam logic [111:0] PKT_CH1   = 112'h55_01_01_01_03_00_44_00_00_00_00_FF_1A_AA;
  localparam logic [111:0] PKT_CH2   = 112'h55_01_02_01_FF_07_30_00_FF_FF_FF_FF_24_AA;
  localparam logic [111:0] PKT_PNUM  = 112'h55_01_01_01_14_00_C7_05_FF_FF_FF_FF_00_AA;
  localparam logic [111:0] PKT_P0    = 112'h55_01_01_01_05_00_00_00_55_55_55_55_00_AA;
  localparam logic [111:0] PKT_OFF1  = 112'h55_01_01_00_03_00_44_00_FF_FF_FF_FF_00_AA;
  localparam logic [111:0] PKT_DDS   = 112'h55_02_12_13_14_15_16_17_18_19_1A_1B_1C_AA;
  localparam logic [111:0] PKT_DDS0  = 112'h55_02_00_00_00_00_00_00_00_00_00_00_00_AA;
  localparam logic [111:0] PKT_IGN   = 112'h55_01_22_23_24_25_26_27_28_29_2A_2B_2C_AA;
  localparam logic [111:0] PKT_BAD   = 112'h55_01_22_23_24_25_26_27_28_29_2A_2B_2C_AB;

  initial begin
    logic [111:0] pk;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_txd", {31'd0, txd}, 32'd1);

    // Channel 1: 69-clock cycles, 3 high, 8 on / 24 off
    exp_led = 1'b1;
    xfer(PKT_CH1, 8'hA5, "ch1");
    measure(2208);
    check("ch1_hi", hi_p, 24);
    check("ch1_rise", rise_p, 8);
    check("ch1_gap", min_gap, 69);
    check("ch1_run", max_run, 3);
    check("ch1_diff", diff_err, 0);
    check("ch1_slow", hi_s, 0);

    // Channel 2: 1841-clock cycle, 255 high, continuous; channel 1 unchanged
    exp_led = 1'b0;
    xfer(PKT_CH2, 8'hA5, "ch2");
    measure(3682);
    check("ch2_hi", hi_s, 510);
    measure(2208);
    check("ch2_ch1_hi", hi_p, 24);

    // pulse_num 5 with 200-clock cycles: remaining four cycles of 20 high, then stop
    exp_led = 1'b1;
    xfer(PKT_PNUM, 8'hA5, "pnum");
    measure(1200);
    check("pnum_hi", hi_p, 80);
    check("pnum_rise", rise_p, 4);

    // period 0 with duty > period: one-clock cycles following PAT 0x55555555
    exp_led = 1'b0;
    xfer(PKT_P0, 8'hA5, "p0");
    measure(200);
    check("p0_hi", hi_p, 100);
    check("p0_run", max_run, 1);

    // Disable channel 1
    exp_led = 1'b1;
    xfer(PKT_OFF1, 8'hA5, "off1");
    measure(100);
    check("off1_hi", hi_p, 0);

    // DDS enable: full swing 0x01..0xFF
    exp_led = 1'b0;
    xfer(PKT_DDS, 8'hA5, "dds");
    check("dds_sleep", {31'd0, sleep}, 32'd0);
    measure(2000);
    check("dds_min", {24'd0, dmin}, 32'h01);
    check("dds_max", {24'd0, dmax}, 32'hFF);

    // DDS disable
    exp_led = 1'b1;
    xfer(PKT_DDS0, 8'hA5, "dds0");
    repeat (3) @(negedge clk);
    check("dds0_dac", {24'd0, dac}, 32'h80);
    check("dds0_sleep", {31'd0, sleep}, 32'd1);

    // Unknown channel: acknowledged, no change; bad tail: nak, LED held
    exp_led = 1'b0;
    xfer(PKT_IGN, 8'hA5, "ign");
    measure(3682);
    check("ign_slow", hi_s, 510);
    check("ign_ch1", hi_p, 0);
    xfer(PKT_BAD, 8'hEE, "bad");

    // Reset during byte 7 of a packet
    pk = PKT_CH1;
    for (int i = 0; i < 7; i++) send_byte(pk[111-8*i -: 8]);
    rxd = 1'b0;
    repeat (3 * BIT) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("mid");
    rxd = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    exp_led = 1'b1;
    xfer(PKT_CH1, 8'hA5, "post");
    measure(2208);
    check("post_hi", hi_p, 24);
    check("post_slow", hi_s, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/dds_sample_top.md
DDS_SAMPLE_TOP -- requirements
Module: dds_sample_top

Interface
REQ-001 Parameter CLK_FREQ, default 50_000_000; sys_clk frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 115200; UART bit rate. Bit period = CLK_FREQ/BAUD_RATE, truncated (434 clocks).
REQ-003 sys_clk  in  1  sole clock; every register is clocked on its rising edge.
REQ-004 sys_rst_n  in  1  reset; asynchronous and active-low.
REQ-005 uart_rxd  in  1  UART command input, 8N1, LSB first, idle high.
REQ-006 uart_txd  out  1  UART acknowledge output, 8N1, idle high.
REQ-007 led  out  1  packet-activity indicator.
REQ-008 pwm_port  out  1  PWM channel 1.
REQ-009 pwm_slow_port  out  1  PWM channel 2.
REQ-010 pwm_diff_port_p / pwm_diff_port_n  out  1 each  channel 1 differential pair (p = pwm_port, n = ~pwm_port).
REQ-011 dac_data  out  8  DDS sine sample, unsigned offset binary.
REQ-012 ad9748_sleep  out  1  DAC sleep (1 = sleep).
REQ-013 adc_clk_p / adc_clk_n and dds_clk0_p / dds_clk0_n  out  1 each  sys_clk/2 clocks (n = ~p).
REQ-014 debug_uart_tx  out  1  combinational copy of uart_rxd.
REQ-015 debug_uart_rx  out  1  combinational copy of uart_txd.

Function
REQ-016 UART RX
- Start bit detected on a falling edge of a 2-flop-synchronised uart_rxd.
- Each bit sampled at its mid-point.
- A byte is discarded if its stop bit is 0.
REQ-017 Packet format: 14 bytes, B0..B13.
- B0 = 0x55 header, B1 = func, B2 = ch, B3 = ctrl, B4 = duty, B5:B6 = period (big-endian).
- B7 = pulse_num, B8..B11 = PAT (big-endian, B8 = MSB), B12 = CRC, B13 = 0xAA tail.
REQ-018 Parser states: IDLE, then PAYLOAD (counts B1..B12), then TAIL.
- In IDLE, all bytes other than 0x55 are ignored.
- The CRC byte is stored but not validated.
REQ-019 Tail handling:
- Tail = 0xAA: the packet is accepted and applied one clock after the tail byte completes.
- Tail wrong: the packet is discarded with no register change.
- Both cases return the parser to IDLE.
REQ-020 Acknowledge on uart_txd, started within 2 clocks of the tail byte: 0xA5 if accepted, 0xEE if discarded. An ack arriving while a transmit is busy is dropped.
REQ-021 led toggles on every accepted packet.
REQ-022 func 0x01 (PWM config): ch 0x01 selects channel 1, ch 0x02 selects channel 2; any other ch value is accepted, acknowledged, and ignored. ctrl bit0 = enable.
REQ-023 PWM operation on enable:
- Cycle counter runs 0..period, so period+1 clocks per PWM cycle.
- Output is high while count < duty, for any PAT bit set to 1.
- PAT bits are consumed one per PWM cycle, LSB first, wrapping after bit 31.
- A PAT bit of 0 gives a low cycle.
REQ-024 PWM cycle limits:
- pulse_num = 0 runs continuously.
- Otherwise the channel stops low after pulse_num cycles.
- duty > period gives high for the whole cycle; period = 0 gives a 1-clock cycle.
REQ-025 A new config for a channel restarts its counter, PAT index and pulse count on the apply clock. Disable forces the output low on the next clock.
REQ-026 func 0x02 (DDS config): ctrl bit0 = DDS enable; FTW = PAT (32 bits). Any other func is acknowledged and ignored.
REQ-027 DDS operation:
- 32-bit phase accumulator adds FTW every clock while enabled.
- dac_data = sine(phase[31:24]) from a 64-entry quarter-wave table.
- Amplitude is 0x80 ± 127, registered (1-clock latency).
REQ-028 DDS disabled: accumulator held at 0, dac_data = 0x80, ad9748_sleep = 1. Enabled: ad9748_sleep = 0.
REQ-029 The p-side of both sys_clk/2 clocks is a toggle flop, free-running after reset.

Reset
REQ-030 While sys_rst_n = 0, and until the first applicable packet:
- uart_txd = 1, led = 0, both PWM outputs = 0 (diff p = 0, n = 1).
- dac_data = 0x80, ad9748_sleep = 1.
- Clock p-sides = 0, parser IDLE, all config registers 0.
REQ-031 Reset mid-packet or mid-transmit aborts the operation. The first byte after release must be a fresh header.

Verification
REQ-032 Packet 55 01 01 01 03 00 44 00 00 00 00 FF 1A AA -> ack 0xA5, led = 1, pwm_port follows a 69-clock cycle with 3 high clocks for the first 8 cycles, then low for 24 cycles, repeating; pwm_diff n = ~p.
REQ-033 Packet 55 01 02 01 FF 07 30 00 FF FF FF FF 24 AA -> pwm_slow_port 1841-clock cycle with 255 high clocks, continuous; pwm_port unchanged.
REQ-034 Packet 55 02 12 13 ... 18 19 1A 1B 1C AA -> FTW 0x18191A1B, ad9748_sleep = 0, dac_data sweeps 0x01..0xFF, led toggles.
REQ-035 Packet 55 01 22 ... 2C AA -> ack 0xA5, no PWM or DDS change; the same packet with tail 0xAB -> ack 0xEE, led unchanged.
REQ-036 Assert sys_rst_n = 0 during byte 7 of a packet -> all outputs at reset values; the next complete packet is applied correctly.
